// File: rtl/ar429_pkg.sv
// ar429_pkg: constants, FSM encoding and parity helper shared by the ARINC-429 style transmitter and receiver.
// Holds word geometry (WORD_BITS, LABEL_BITS, DATA_BITS), the default line-rate
// constants and the transmitter FSM state type.
package ar429_pkg;
    localparam int WORD_BITS    = 32;
    localparam int LABEL_BITS   = 8;
    localparam int DATA_BITS    = 23;
    localparam int F_CLK_DEF    = 50_000_000;
    localparam int F_BIT_DEF    = 100_000;
    localparam int GAP_BITS_DEF = 4;
    typedef enum logic [1:0] {IDLE, SEND, GAP} ar_state_e;
    // Odd parity bit over the first 31 bits: total number of ones becomes odd.
    function automatic logic odd_par(input logic [WORD_BITS-2:0] v);
        return ~^v;
    endfunction
endpackage

// File: rtl/ar_bit_timer.sv
// ar_bit_timer: half-bit timing for the return-to-zero line code.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   clr   - hold the timer at the start of a bit (high half)
//   tick  - one-clk pulse on the last clock of each half-bit
//   phase - 1 during the high (data) half of a bit, 0 during the low half
module ar_bit_timer import ar429_pkg::*; #(
    parameter int F_CLK = F_CLK_DEF,
    parameter int F_BIT = F_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic phase
);
    localparam int H  = F_CLK / (2 * F_BIT);
    localparam int CW = $clog2(2 * H);
    logic [CW-1:0] cnt;
    assign phase = cnt < CW'(H);
    assign tick  = (cnt == CW'(H - 1)) || (cnt == CW'(2 * H - 1));
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else
            cnt <= (cnt == CW'(2 * H - 1)) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/ar_txd.sv
// ar_txd: ARINC-429 style bipolar return-to-zero word transmitter.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   st     - start request, accepted only in IDLE
//   adr    - 8-bit label, sent MSB first
//   dat    - 23-bit data field, sent LSB first
//   par_in - raw bit 32 when the parity generator is not built in
//   TXD1   - registered "one" line
//   TXD0   - registered "zero" line
//   busy   - high from the accepting edge until the end of the inter-word gap
//   ce_tx  - one-clk pulse in the last gap clock
// Build option: define AR_TXD_PARITY_EN to send odd parity as bit 32 instead of par_in.
module ar_txd import ar429_pkg::*; #(
    parameter int F_CLK    = F_CLK_DEF,
    parameter int F_BIT    = F_BIT_DEF,
    parameter int GAP_BITS = GAP_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st,
    input  logic [LABEL_BITS-1:0] adr,
    input  logic [DATA_BITS-1:0]  dat,
    input  logic                  par_in,
    output logic                  TXD1,
    output logic                  TXD0,
    output logic                  busy,
    output logic                  ce_tx
);
    localparam int GW = $clog2(GAP_BITS + 1);
    ar_state_e            state, nstate;
    logic [WORD_BITS-1:0] sreg;
    logic [4:0]           bcnt;
    logic [GW-1:0]        gcnt;
    logic [DATA_BITS-1:0] drev;
    logic                 par, tick, phase, bit_end, accept;
    ar_bit_timer #(.F_CLK(F_CLK), .F_BIT(F_BIT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE),
        .tick  (tick),
        .phase (phase)
    );
    // Data goes out LSB first while the shift register shifts out its MSB.
    assign drev    = {<<{dat}};
`ifdef AR_TXD_PARITY_EN
    assign par     = odd_par({adr, dat});
`else
    assign par     = par_in;
`endif
    assign bit_end = tick && !phase;
    assign accept  = (state == IDLE) && st;
    assign busy    = state != IDLE;
    assign ce_tx   = (state == GAP) && bit_end && (gcnt == GW'(GAP_BITS - 1));
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = st ? SEND : IDLE;
            SEND:    nstate = (bit_end && bcnt == 5'(WORD_BITS - 1)) ? GAP : SEND;
            GAP:     nstate = ce_tx ? IDLE : GAP;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            bcnt  <= '0;
            gcnt  <= '0;
            TXD1  <= 1'b0;
            TXD0  <= 1'b0;
        end else begin
            state <= nstate;
            // Lines follow the current bit one clock later, so the first high half
            // starts on the edge after the accepting one.
            TXD1  <= (state == SEND) && phase && sreg[WORD_BITS-1];
            TXD0  <= (state == SEND) && phase && !sreg[WORD_BITS-1];
            if (accept) begin
                sreg <= {adr, drev, par};
                bcnt <= '0;
                gcnt <= '0;
            end else if (bit_end && state == SEND) begin
                sreg <= {sreg[WORD_BITS-2:0], 1'b0};
                bcnt <= (bcnt == 5'(WORD_BITS - 1)) ? bcnt : bcnt + 5'd1;
            end else if (bit_end && state == GAP) begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ar_txd.sv
// tb_ar_txd: directed self-checking bench for ar_txd at 50 MHz / 100 kbit/s (H=250).
module tb_ar_txd;
    import ar429_pkg::*;
`ifdef AR_TXD_PARITY_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st = 1'b0;
    logic [7:0]  adr = '0;
    logic [22:0] dat = '0;
    logic        par_in = 1'b0;
    logic        TXD1, TXD0, busy, ce_tx;
    int          total = 0;
    int          bad = 0;

    ar_txd #(.F_CLK(50_000_000), .F_BIT(100_000), .GAP_BITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .adr    (adr),
        .dat    (dat),
        .par_in (par_in),
        .TXD1   (TXD1),
        .TXD0   (TXD0),
        .busy   (busy),
        .ce_tx  (ce_tx)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called just after the accepting edge (cycle n=0). Walks cycles n=1..18000
    // against the expected RZ waveform of word w (bit 1 at w[31]).
    task automatic run_word(input string tag, input logic [31:0] w, input bit held);
        int          e_line = 0;
        int          e_busy = 0;
        int          n_ce = 0;
        int          ce_at = 0;
        int          k;
        logic        hi, b, x1, x0;
        logic [31:0] rx = '0;
        for (int n = 1; n <= 18000; n++) begin
            @(posedge clk);
            #1;
            k  = (n - 1) / 500;
            hi = ((n - 1) % 500) < 250;
            b  = (n <= 16000) ? w[31 - k] : 1'b0;
            x1 = (n <= 16000) && hi && b;
            x0 = (n <= 16000) && hi && !b;
            if (TXD1 !== x1 || TXD0 !== x0) e_line++;
            if (busy !== (n < 18000)) e_busy++;
            if (ce_tx === 1'b1) begin
                n_ce++;
                ce_at = n;
            end
            if (n <= 16000 && (n - 1) % 500 == 0) rx = {rx[30:0], TXD1};
            if (!held) st = (n == 5000) || (n == 17999);
        end
        chk({tag, "_line_errs"}, e_line, 0);
        chk({tag, "_busy_errs"}, e_busy, 0);
        chk({tag, "_ce_count"}, n_ce, 1);
        chk({tag, "_ce_cycle"}, ce_at, 17999);
        chk({tag, "_word"}, rx, w);
    endtask

    task automatic start(input logic [7:0] a, input logic [22:0] d, input logic p);
        adr = a;
        dat = d;
        par_in = p;
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        adr = ~a;
        dat = ~d;
        par_in = ~p;
    endtask

    initial begin
        int act;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd1", TXD1, 0);
        chk("rst_txd0", TXD0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ce", ce_tx, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        start(8'hA5, 23'h000001, 1'b1);
        chk("w1_busy_at_accept", busy, 1);
        chk("w1_quiet_at_accept", {TXD1, TXD0}, 2'b00);
        run_word("w1", 32'hA580_0000 | (PE ? 32'd0 : 32'd1), 1'b0);
        @(posedge clk);
        #1;
        chk("w1_st_at_ce_ignored", busy, 0);

        start(8'h00, 23'h000000, 1'b0);
        run_word("w2", PE ? 32'd1 : 32'd0, 1'b0);
        @(posedge clk);
        #1;

        start(8'hA5, 23'h000001, 1'b1);
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (n == 2600) chk("rst_mid_high", TXD1, 1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstw_txd1", TXD1, 0);
        chk("rstw_txd0", TXD0, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_ce", ce_tx, 0);
        act = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if (TXD1 || TXD0 || busy || ce_tx) act++;
        end
        chk("rstw_no_resume", act, 0);

        adr = 8'hFF;
        dat = 23'h400000;
        par_in = 1'b1;
        st = 1'b1;
        @(posedge clk);
        #1;
        chk("w3_busy_at_accept", busy, 1);
        run_word("w3a", 32'hFF00_0002 | (PE ? 32'd0 : 32'd1), 1'b1);
        @(posedge clk);
        #1;
        chk("w3_reaccept_busy", busy, 1);
        chk("w3_reaccept_quiet", {TXD1, TXD0}, 2'b00);
        run_word("w3b", 32'hFF00_0002 | (PE ? 32'd0 : 32'd1), 1'b1);
        st = 1'b0;
        @(posedge clk);
        #1;
        chk("w3_end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
